// File: rtl/sram_param.sv
// Shared SRAM geometry, timing and owner-tag definitions for the SRAM access arbiter.
package sram_param;

    localparam int SRAM_ADDR_COUNT     = 20;
    localparam int SRAM_DATA_WIDTH     = 16;
    localparam int SRAM_READ_LAT       = 2;
    localparam int SRAM_AUX_STARVE_MAX = 8;

    typedef enum logic [1:0] {
        OWN_NONE   = 2'd0,
        OWN_RENDER = 2'd1,
        OWN_AUX    = 2'd2
    } owner_t;

endpackage

// File: rtl/sram_owner_pipe.sv
// Owner-tag shift register that follows every in-flight SRAM read until its data returns.
module sram_owner_pipe
    import sram_param::*;
#(
    parameter int DEPTH = SRAM_READ_LAT
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] tag_i,
    output logic [1:0] tag_o,
    output logic       empty_o
);

    owner_t stage_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= OWN_NONE;
        end else begin
            stage_q[0] <= owner_t'(tag_i);
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    // Empty means no read can return on DQ while a write would be driving it.
    always_comb begin
        empty_o = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            if (stage_q[i] != OWN_NONE) empty_o = 1'b0;
        end
    end

    assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/sram_access_arbiter.sv
// Shares one external SRAM port: render reads have priority, aux reads/writes use idle slots.
// Define SRAM_ARB_STARVE_GUARD_EN to force an aux grant after AUX_STARVE_MAX denied cycles.
module sram_access_arbiter
    import sram_param::*;
#(
    parameter int ADDR_W         = SRAM_ADDR_COUNT,
    parameter int DATA_W         = SRAM_DATA_WIDTH,
    parameter int READ_LAT       = SRAM_READ_LAT,
    parameter int AUX_STARVE_MAX = SRAM_AUX_STARVE_MAX
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_rd_req,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic              o_rd_valid,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_drop,
    input  logic              i_aux_req,
    input  logic              i_aux_we,
    input  logic [ADDR_W-1:0] i_aux_addr,
    input  logic [DATA_W-1:0] i_aux_wdata,
    output logic              o_aux_gnt,
    output logic              o_aux_rvalid,
    output logic [DATA_W-1:0] o_aux_rdata,
    output logic [ADDR_W-1:0] o_SRAM_ADDR,
    inout  wire  [DATA_W-1:0] io_SRAM_DQ,
    output logic              o_SRAM_WE_N
);

    logic              rdIssue;
    logic              auxIssue;
    logic              auxOk;
    logic              auxForce;
    logic              pipeEmpty;
    logic [1:0]        issueTag_d;
    logic [1:0]        retTag;
    logic [1:0]        sampleOwner_q;
    logic [ADDR_W-1:0] sramAddr_q;
    logic              sramWeN_q;
    logic [DATA_W-1:0] wdata_q;
    logic              rdValid_q;
    logic [DATA_W-1:0] rdData_q;
    logic              auxRvalid_q;
    logic [DATA_W-1:0] auxRdata_q;

`ifdef SRAM_ARB_STARVE_GUARD_EN
    localparam int               CNT_W        = $clog2(AUX_STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIMIT = CNT_W'(AUX_STARVE_MAX);

    logic [CNT_W-1:0] starveCnt_q;
    logic [CNT_W-1:0] starveCnt_d;

    assign auxForce  = i_aux_req && (starveCnt_q == STARVE_LIMIT);
    assign o_rd_drop = i_rst_n && i_rd_req && auxForce;

    always_comb begin
        starveCnt_d = starveCnt_q;
        if (auxIssue) starveCnt_d = '0;
        else if (i_aux_req && (starveCnt_q != STARVE_LIMIT)) starveCnt_d = starveCnt_q + 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) starveCnt_q <= '0;
        else          starveCnt_q <= starveCnt_d;
    end
`else
    logic unusedStarveMax;
    assign unusedStarveMax = ^AUX_STARVE_MAX;
    assign auxForce        = 1'b0;
    assign o_rd_drop       = 1'b0;
`endif

    // Aux writes wait for an empty pipe so write data never collides with returning reads.
    always_comb begin
        auxOk    = i_aux_req && (!i_aux_we || pipeEmpty);
        rdIssue  = 1'b0;
        auxIssue = 1'b0;
        if (auxForce)      auxIssue = auxOk;
        else if (i_rd_req) rdIssue  = 1'b1;
        else               auxIssue = auxOk;
        issueTag_d = OWN_NONE;
        if (rdIssue)                    issueTag_d = OWN_RENDER;
        else if (auxIssue && !i_aux_we) issueTag_d = OWN_AUX;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sramAddr_q <= '0;
            sramWeN_q  <= 1'b1;
            wdata_q    <= '0;
        end else begin
            sramWeN_q <= 1'b1;
            if (rdIssue) begin
                sramAddr_q <= i_rd_addr;
            end else if (auxIssue) begin
                sramAddr_q <= i_aux_addr;
                sramWeN_q  <= !i_aux_we;
                wdata_q    <= i_aux_wdata;
            end
        end
    end

    sram_owner_pipe #(
        .DEPTH (READ_LAT)
    ) uOwnerPipe (
        .clk_i   (i_clk),
        .rst_ni  (i_rst_n),
        .tag_i   (issueTag_d),
        .tag_o   (retTag),
        .empty_o (pipeEmpty)
    );

    // The tag leaving the pipe names the owner of the word on DQ in the following cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sampleOwner_q <= OWN_NONE;
            rdValid_q     <= 1'b0;
            rdData_q      <= '0;
            auxRvalid_q   <= 1'b0;
            auxRdata_q    <= '0;
        end else begin
            sampleOwner_q <= retTag;
            rdValid_q     <= (sampleOwner_q == OWN_RENDER);
            auxRvalid_q   <= (sampleOwner_q == OWN_AUX);
            if (sampleOwner_q == OWN_RENDER) rdData_q   <= io_SRAM_DQ;
            if (sampleOwner_q == OWN_AUX)    auxRdata_q <= io_SRAM_DQ;
        end
    end

    assign io_SRAM_DQ   = sramWeN_q ? {DATA_W{1'bz}} : wdata_q;
    assign o_SRAM_ADDR  = sramAddr_q;
    assign o_SRAM_WE_N  = sramWeN_q;
    assign o_aux_gnt    = i_rst_n && auxIssue;
    assign o_rd_valid   = rdValid_q;
    assign o_rd_data    = rdData_q;
    assign o_aux_rvalid = auxRvalid_q;
    assign o_aux_rdata  = auxRdata_q;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Directed bench for sram_access_arbiter with a 2-cycle-latency SRAM model (data = addr[15:0] unless written).
// Starvation expectations follow SRAM_ARB_STARVE_GUARD_EN, the same define used for the DUT build.
module tb_sram_access_arbiter;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

`ifdef SRAM_ARB_STARVE_GUARD_EN
    localparam int   GNT_CYCLE = 8;
    localparam logic GUARD     = 1'b1;
`else
    localparam int   GNT_CYCLE = 20;
    localparam logic GUARD     = 1'b0;
`endif

    typedef struct {
        logic        rdReq;
        logic [19:0] rdAddr;
        logic        auxReq;
        logic        auxWe;
        logic [19:0] auxAddr;
        logic [15:0] auxWdata;
        logic        expGnt;
        logic        expRv;
        logic [15:0] expRd;
        logic        expArv;
        logic [15:0] expArd;
        logic        expWeN;
        logic [19:0] expAddr;
        logic [15:0] expDq;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstN;
    logic        rdReq;
    logic [19:0] rdAddr;
    logic        rdValid;
    logic [15:0] rdData;
    logic        rdDrop;
    logic        auxReq;
    logic        auxWe;
    logic [19:0] auxAddr;
    logic [15:0] auxWdata;
    logic        auxGnt;
    logic        auxRvalid;
    logic [15:0] auxRdata;
    logic [19:0] sramAddr;
    logic        sramWeN;
    wire  [15:0] sramDq;

    logic        probeEn   = 1'b0;
    logic [15:0] modelData = 16'h0;
    logic [19:0] h0 = '0, h1 = '0, h2 = '0;
    logic [15:0] mem [int];

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    sram_access_arbiter dut (
        .i_clk        (clk),
        .i_rst_n      (rstN),
        .i_rd_req     (rdReq),
        .i_rd_addr    (rdAddr),
        .o_rd_valid   (rdValid),
        .o_rd_data    (rdData),
        .o_rd_drop    (rdDrop),
        .i_aux_req    (auxReq),
        .i_aux_we     (auxWe),
        .i_aux_addr   (auxAddr),
        .i_aux_wdata  (auxWdata),
        .o_aux_gnt    (auxGnt),
        .o_aux_rvalid (auxRvalid),
        .o_aux_rdata  (auxRdata),
        .o_SRAM_ADDR  (sramAddr),
        .io_SRAM_DQ   (sramDq),
        .o_SRAM_WE_N  (sramWeN)
    );

    // The probe drives a known pattern so a released bus reads back as that pattern.
    assign sramDq = probeEn ? 16'hA5A5 : (sramWeN ? modelData : 16'hzzzz);

    function automatic logic [15:0] memRead(input logic [19:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return a[15:0];
    endfunction

    // DQ during cycle c carries the word addressed in cycle c-2.
    always @(negedge clk) begin
        h2 = h1;
        h1 = h0;
        h0 = sramAddr;
        if (!sramWeN) mem[int'(sramAddr)] = sramDq;
        modelData = memRead(h2);
    end

    function automatic vec_t mkVec(input logic rr, input logic [19:0] ra, input logic ar, input logic aw,
                                   input logic [19:0] aa, input logic [15:0] ad, input logic gnt,
                                   input logic rv, input logic [15:0] rd, input logic arv,
                                   input logic [15:0] ard, input logic wen, input logic [19:0] addr,
                                   input logic [15:0] dq);
        vec_t v;
        v.rdReq = rr; v.rdAddr = ra; v.auxReq = ar; v.auxWe = aw; v.auxAddr = aa; v.auxWdata = ad;
        v.expGnt = gnt; v.expRv = rv; v.expRd = rd; v.expArv = arv; v.expArd = ard;
        v.expWeN = wen; v.expAddr = addr; v.expDq = dq;
        return v;
    endfunction

    task automatic applyStimulus(input logic rr, input logic [19:0] ra, input logic ar, input logic aw,
                                 input logic [19:0] aa, input logic [15:0] ad);
        rdReq = rr; rdAddr = ra; auxReq = ar; auxWe = aw; auxAddr = aa; auxWdata = ad;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_rv"},   32'(rdValid),   32'h0);
        checkOutput({tag, "_rd"},   32'(rdData),    32'h0);
        checkOutput({tag, "_arv"},  32'(auxRvalid), 32'h0);
        checkOutput({tag, "_ard"},  32'(auxRdata),  32'h0);
        checkOutput({tag, "_gnt"},  32'(auxGnt),    32'h0);
        checkOutput({tag, "_drop"}, 32'(rdDrop),    32'h0);
        checkOutput({tag, "_addr"}, 32'(sramAddr),  32'h0);
        checkOutput({tag, "_wen"},  32'(sramWeN),   32'h1);
        checkOutput({tag, "_dq"},   32'(sramDq),    32'hA5A5);
    endtask

    initial begin
        // rr  ra      ar aw aa       ad        gnt rv rd        arv ard       wen addr      dq
        vecs.push_back(mkVec(H, 20'h10, L, L, 20'h0, 16'h0, L, L, 16'h0, L, 16'h0, H, 20'h0, 16'h0));
        vecs.push_back(mkVec(H, 20'h11, L, L, 20'h0, 16'h0, L, L, 16'h0, L, 16'h0, H, 20'h10, 16'h0));
        vecs.push_back(mkVec(H, 20'h12, L, L, 20'h0, 16'h0, L, L, 16'h0, L, 16'h0, H, 20'h11, 16'h0));
        vecs.push_back(mkVec(H, 20'h13, L, L, 20'h0, 16'h0, L, L, 16'h0, L, 16'h0, H, 20'h12, 16'h0));
        vecs.push_back(mkVec(L, 20'h0, H, L, 20'h100, 16'h0, H, H, 16'h10, L, 16'h0, H, 20'h13, 16'h0));
        vecs.push_back(mkVec(L, 20'h0, L, L, 20'h0, 16'h0, L, H, 16'h11, L, 16'h0, H, 20'h100, 16'h0));
        vecs.push_back(mkVec(L, 20'h0, L, L, 20'h0, 16'h0, L, H, 16'h12, L, 16'h0, H, 20'h100, 16'h0));
        vecs.push_back(mkVec(L, 20'h0, L, L, 20'h0, 16'h0, L, H, 16'h13, L, 16'h0, H, 20'h100, 16'h0));
        vecs.push_back(mkVec(L, 20'h0, L, L, 20'h0, 16'h0, L, L, 16'h0, H, 16'h100, H, 20'h100, 16'h0));
        vecs.push_back(mkVec(H, 20'h20, L, L, 20'h0, 16'h0, L, L, 16'h0, L, 16'h0, H, 20'h100, 16'h0));
        vecs.push_back(mkVec(L, 20'h0, H, L, 20'h21, 16'h0, H, L, 16'h0, L, 16'h0, H, 20'h20, 16'h0));
        vecs.push_back(mkVec(H, 20'h22, L, L, 20'h0, 16'h0, L, L, 16'h0, L, 16'h0, H, 20'h21, 16'h0));
        vecs.push_back(mkVec(L, 20'h0, H, L, 20'h23, 16'h0, H, L, 16'h0, L, 16'h0, H, 20'h22, 16'h0));
        vecs.push_back(mkVec(H, 20'h24, L, L, 20'h0, 16'h0, L, H, 16'h20, L, 16'h0, H, 20'h23, 16'h0));
        vecs.push_back(mkVec(L, 20'h0, L, L, 20'h0, 16'h0, L, L, 16'h0, H, 16'h21, H, 20'h24, 16'h0));
        vecs.push_back(mkVec(L, 20'h0, L, L, 20'h0, 16'h0, L, H, 16'h22, L, 16'h0, H, 20'h24, 16'h0));
        vecs.push_back(mkVec(L, 20'h0, L, L, 20'h0, 16'h0, L, L, 16'h0, H, 16'h23, H, 20'h24, 16'h0));
        vecs.push_back(mkVec(L, 20'h0, L, L, 20'h0, 16'h0, L, H, 16'h24, L, 16'h0, H, 20'h24, 16'h0));
        vecs.push_back(mkVec(L, 20'h0, L, L, 20'h0, 16'h0, L, L, 16'h0, L, 16'h0, H, 20'h24, 16'h0));
        // Aux write held while two render reads drain, then read back.
        vecs.push_back(mkVec(H, 20'h30, L, L, 20'h0, 16'h0, L, L, 16'h0, L, 16'h0, H, 20'h24, 16'h0));
        vecs.push_back(mkVec(H, 20'h31, L, L, 20'h0, 16'h0, L, L, 16'h0, L, 16'h0, H, 20'h30, 16'h0));
        vecs.push_back(mkVec(L, 20'h0, H, H, 20'h200, 16'hBEEF, L, L, 16'h0, L, 16'h0, H, 20'h31, 16'h0));
        vecs.push_back(mkVec(L, 20'h0, H, H, 20'h200, 16'hBEEF, L, L, 16'h0, L, 16'h0, H, 20'h31, 16'h0));
        vecs.push_back(mkVec(L, 20'h0, H, H, 20'h200, 16'hBEEF, H, H, 16'h30, L, 16'h0, H, 20'h31, 16'h0));
        vecs.push_back(mkVec(H, 20'h32, L, L, 20'h0, 16'h0, L, H, 16'h31, L, 16'h0, L, 20'h200, 16'hBEEF));
        vecs.push_back(mkVec(L, 20'h0, H, L, 20'h200, 16'h0, H, L, 16'h0, L, 16'h0, H, 20'h32, 16'h0));
        vecs.push_back(mkVec(L, 20'h0, L, L, 20'h0, 16'h0, L, L, 16'h0, L, 16'h0, H, 20'h200, 16'h0));
        vecs.push_back(mkVec(L, 20'h0, L, L, 20'h0, 16'h0, L, L, 16'h0, L, 16'h0, H, 20'h200, 16'h0));
        vecs.push_back(mkVec(L, 20'h0, L, L, 20'h0, 16'h0, L, H, 16'h32, L, 16'h0, H, 20'h200, 16'h0));
        vecs.push_back(mkVec(L, 20'h0, L, L, 20'h0, 16'h0, L, L, 16'h0, H, 16'hBEEF, H, 20'h200, 16'h0));
        vecs.push_back(mkVec(L, 20'h0, L, L, 20'h0, 16'h0, L, L, 16'h0, L, 16'h0, H, 20'h200, 16'h0));

        // Reset with requests asserted: nothing may be granted or issued.
        rstN    = 1'b0;
        probeEn = 1'b1;
        applyStimulus(H, 20'h5, H, L, 20'h7, 16'h0);
        #12;
        checkResetState("rst0");
        @(negedge clk);
        applyStimulus(L, 20'h0, L, L, 20'h0, 16'h0);
        rstN    = 1'b1;
        probeEn = 1'b0;

        foreach (vecs[i]) begin
            @(posedge clk); #1;
            applyStimulus(vecs[i].rdReq, vecs[i].rdAddr, vecs[i].auxReq, vecs[i].auxWe,
                          vecs[i].auxAddr, vecs[i].auxWdata);
            #2;
            checkOutput($sformatf("v%0d_gnt", i),  32'(auxGnt),    32'(vecs[i].expGnt));
            checkOutput($sformatf("v%0d_drop", i), 32'(rdDrop),    32'h0);
            checkOutput($sformatf("v%0d_rv", i),   32'(rdValid),   32'(vecs[i].expRv));
            checkOutput($sformatf("v%0d_arv", i),  32'(auxRvalid), 32'(vecs[i].expArv));
            checkOutput($sformatf("v%0d_wen", i),  32'(sramWeN),   32'(vecs[i].expWeN));
            checkOutput($sformatf("v%0d_addr", i), 32'(sramAddr),  32'(vecs[i].expAddr));
            if (vecs[i].expRv)   checkOutput($sformatf("v%0d_rd", i),  32'(rdData),   32'(vecs[i].expRd));
            if (vecs[i].expArv)  checkOutput($sformatf("v%0d_ard", i), 32'(auxRdata), 32'(vecs[i].expArd));
            if (!vecs[i].expWeN) checkOutput($sformatf("v%0d_dq", i),  32'(sramDq),   32'(vecs[i].expDq));
        end

        // Render requests every cycle while an aux read waits.
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            applyStimulus(i < 20, 20'(32'h40 + i), i <= GNT_CYCLE, L, 20'h300, 16'h0);
            #2;
            checkOutput($sformatf("starve%0d_gnt", i),  32'(auxGnt),    32'(i == GNT_CYCLE));
            checkOutput($sformatf("starve%0d_drop", i), 32'(rdDrop),    32'(GUARD && (i == GNT_CYCLE)));
            checkOutput($sformatf("starve%0d_arv", i),  32'(auxRvalid), 32'(i == GNT_CYCLE + 4));
            checkOutput($sformatf("starve%0d_both", i), 32'(rdValid && auxRvalid), 32'h0);
            if (i == GNT_CYCLE + 4) checkOutput("starve_ard", 32'(auxRdata), 32'h0300);
        end

        // Reset with two render reads in flight and an aux read held across it.
        @(posedge clk); #1;
        applyStimulus(H, 20'h50, L, L, 20'h0, 16'h0);
        @(posedge clk); #1;
        applyStimulus(H, 20'h51, L, L, 20'h0, 16'h0);
        @(posedge clk); #1;
        applyStimulus(L, 20'h0, H, L, 20'h60, 16'h0);
        probeEn = 1'b1;
        rstN    = 1'b0;
        #1;
        checkResetState("rstmid");
        repeat (2) @(posedge clk);
        #1;
        rstN    = 1'b1;
        probeEn = 1'b0;
        #1;
        checkOutput("rearb_gnt", 32'(auxGnt), 32'h1);
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            applyStimulus(L, 20'h0, L, L, 20'h0, 16'h0);
            #2;
            checkOutput($sformatf("post%0d_rv", k),  32'(rdValid),   32'h0);
            checkOutput($sformatf("post%0d_arv", k), 32'(auxRvalid), 32'(k == 4));
            if (k == 1) checkOutput("post_addr", 32'(sramAddr), 32'h60);
            if (k == 4) checkOutput("post_ard",  32'(auxRdata), 32'h0060);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
